seq_mul_unit: RTL and testbench

//  Multi-cycle shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
//  - Sits in the EX stage beside the ALU and instantiates one N_bit_RCA (N wide) as its only adder.
//  - Each iteration adds the multiplicand into the upper product half and consumes the adder's sum and cout.
//  - Start/busy/done handshake stalls the pipeline; the N-bit result feeds the EX/MEM result mux.

---
 rtl/seq_mul_unit.sv | 182 ++++++++++++++++++
 tb/tb_seq_mul_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) built around one ripple-carry adder.
// Optional: define SEQ_MUL_EARLY_EXIT_EN to leave RUN once the remaining multiplier bits are zero.

module N_bit_RCA #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];
endmodule

module seq_mul_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         flush,
    input  logic [1:0]   mul_op,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_SIGN = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic                 neg_q;
    logic [N-1:0]         mcand_q;
    logic [2*N-1:0]       prod_q;
    logic [CW-1:0]        count_q;
    logic [N-1:0]         result_q;

    logic                 sa, sb;
    logic [N-1:0]         abs_a, abs_b;
    logic [N-1:0]         addend, sum;
    logic                 cout;
    logic [2*N-1:0]       step_prod, run_prod;
    logic                 exit_run;
    logic                 accept;
    logic [N-1:0]         sel_res;

    // Two's complement without a carry chain: flip every bit above the lowest set bit.
    function automatic logic [N-1:0] neg_word(input logic [N-1:0] x);
        logic [N-1:0] r;
        logic         seen;
        seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            r[i] = x[i] ^ seen;
            seen = seen | x[i];
        end
        return r;
    endfunction

    function automatic logic [2*N-1:0] neg_prod(input logic [2*N-1:0] x);
        logic [2*N-1:0] r;
        logic           seen;
        seen = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            r[i] = x[i] ^ seen;
            seen = seen | x[i];
        end
        return r;
    endfunction

    assign sa     = operand_a[N-1] & ((mul_op == OP_MULH) | (mul_op == OP_MULHSU));
    assign sb     = operand_b[N-1] & (mul_op == OP_MULH);
    assign abs_a  = sa ? neg_word(operand_a) : operand_a;
    assign abs_b  = sb ? neg_word(operand_b) : operand_b;
    assign accept = (state_q == S_IDLE) && start && !flush;

    assign addend = prod_q[0] ? mcand_q : '0;

    N_bit_RCA #(.N(N)) u_rca (
        .a    (prod_q[2*N-1:N]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign step_prod = {cout, sum, prod_q[N-1:1]};

`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic [N-2:0] rem_bits;
    logic [CW-1:0] shamt;

    // Multiplier bits not yet consumed after this iteration, aligned so zero means nothing left to add.
    assign rem_bits = prod_q[N-1:1] << count_q;
    assign shamt    = CW'(N - 1) - count_q;
    assign exit_run = (rem_bits == '0);
    assign run_prod = exit_run ? (step_prod >> shamt) : step_prod;
`else
    assign exit_run = (count_q == CW'(N - 1));
    assign run_prod = step_prod;
`endif

    assign sel_res = (op_q == OP_MUL) ? prod_q[N-1:0] : prod_q[2*N-1:N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN: begin
                if (flush)         state_d = S_IDLE;
                else if (exit_run) state_d = S_SIGN;
            end
            S_SIGN:  state_d = flush ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE) && !flush;
        result = done ? sel_res : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= mul_op;
                neg_q   <= sa ^ sb;
                mcand_q <= abs_a;
                prod_q  <= {{N{1'b0}}, abs_b};
                count_q <= '0;
            end else if (!flush) begin
                case (state_q)
                    S_RUN: begin
                        prod_q  <= run_prod;
                        count_q <= count_q + 1'b1;
                    end
                    S_SIGN: if (neg_q) prod_q <= neg_prod(prod_q);
                    S_DONE: result_q <= sel_res;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed-vector bench for seq_mul_unit: latency, result value, busy-start, flush and reset behaviour.

module tb_seq_mul_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  mul_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_pass;
    int n_total;

    seq_mul_unit #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .mul_op    (mul_op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int pick_lat(input int ee_lat);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        return ee_lat;
`else
        return (ee_lat > 0) ? 34 : 34;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int ee_lat);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; mul_op = op; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(pick_lat(ee_lat)));
        check({tag, "_res"}, result, exp);
    endtask

    initial begin
        int lat;
        int done_seen;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        mul_op = 2'b00; operand_a = '0; operand_b = '0;

        #12;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_result", result,    32'd0);
        rst_n = 1'b1;

        run_op("mulhu_ff",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mul_ff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
        run_op("mulh_m3x7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 5);
        run_op("mul_m3x7",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 5);
        run_op("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("mulh_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu_x3",  2'b11, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 4);
        run_op("mul_x3",    2'b00, 32'h1234_5678, 32'h0000_0003, 32'h369D_0368, 4);
        run_op("mul_zero",  2'b00, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 3);

        // Second start while busy must be ignored.
        @(posedge clk); #1;
        start = 1'b1; mul_op = 2'b00; operand_a = 32'd7; operand_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin
                start = 1'b1; mul_op = 2'b11;
                operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_ign_lat", 32'(lat), 32'(pick_lat(5)));
        check("busy_ign_res", result, 32'd42);
        @(posedge clk); #1;
        check("busy_ign_idle", 32'(busy), 32'd0);

        // Flush at t+10: idle at t+11, no done, result keeps 42.
        @(posedge clk); #1;
        start = 1'b1; mul_op = 2'b11; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0; lat = 1; done_seen = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (done) done_seen++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("flush_nodone", 32'(done_seen), 32'd0);
        check("flush_result", result, 32'd42);

        // Flush in IDLE outranks start.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; mul_op = 2'b00; operand_a = 32'd3; operand_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN.
        @(posedge clk); #1;
        start = 1'b1; mul_op = 2'b11; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("midrun_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy",   32'(busy), 32'd0);
        check("midrun_rst_done",   32'(done), 32'd0);
        check("midrun_rst_result", result,    32'd0);
        #4;
        rst_n = 1'b1;
        run_op("post_rst", 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
